// File: rtl/flop_array_mp.sv
// rtl/flop_array_mp.sv - multi-read-port, single-write-port flop array with valid tracking
// Optional feature macro: FFA_WR_BYPASS_EN (write-to-read forwarding on same-address collision)
module flop_array_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_N   = 8,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            din,
  input  logic                         clr,
  input  logic [RD_PORTS-1:0]          rd,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   dout,
  output logic [RD_PORTS-1:0]          rd_v,
  output logic [RD_PORTS-1:0]          rd_hit,
  output logic                         error,
  output logic                         err_sticky,
  output logic [ADDR_W:0]              valid_cnt
);

  // Entry storage (not reset) and per-entry valid bits
  logic [DATA_W-1:0]          mem_q [DATA_N];
  logic [DATA_N-1:0]          valid_q;
  logic [DATA_N-1:0]          valid_d;

  // Write decode
  logic [DATA_N-1:0]          wr_sel;
  logic                       wr_in;
  logic                       wr_oor;

  // Registered read responses and status
  logic [RD_PORTS*DATA_W-1:0] dout_q, dout_d;
  logic [RD_PORTS-1:0]        rd_v_q;
  logic [RD_PORTS-1:0]        hit_q, hit_d;
  logic                       err_q, err_d;
  logic                       err_sticky_q;
  logic [ADDR_W:0]            cnt_q, cnt_d;

  // Per-port lookup results
  logic [ADDR_W-1:0]          ra    [RD_PORTS];
  logic [DATA_W-1:0]          ent_d [RD_PORTS];
  logic [RD_PORTS-1:0]        ent_v;
  logic [RD_PORTS-1:0]        in_rng;
  logic [RD_PORTS-1:0]        coll;
  logic                       rd_err;

  // Decode the write address onto implemented entries; anything else is out of range
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DATA_N; i++) begin
      wr_sel[i] = wr && (waddr == ADDR_W'(i));
    end
    wr_in  = |wr_sel;
    wr_oor = wr && !wr_in;
  end

  // Look up each read port against the pre-edge state and build its response
  always_comb begin
    dout_d = '0;
    hit_d  = '0;
    ent_v  = '0;
    in_rng = '0;
    coll   = '0;
    rd_err = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ra[p]    = raddr[p*ADDR_W +: ADDR_W];
      ent_d[p] = '0;
      for (int i = 0; i < DATA_N; i++) begin
        if (ra[p] == ADDR_W'(i)) begin
          ent_d[p]  = mem_q[i];
          ent_v[p]  = valid_q[i];
          in_rng[p] = 1'b1;
        end
      end
      coll[p] = in_rng[p] && wr_in && (waddr == ra[p]);
      if (rd[p]) begin
        if (!in_rng[p]) begin
          rd_err = 1'b1;
        end else if (coll[p]) begin
`ifdef FFA_WR_BYPASS_EN
          dout_d[p*DATA_W +: DATA_W] = din;
          hit_d[p]                   = 1'b1;
`else
          // Old content is returned; the write still lands at the edge
          if (ent_v[p]) begin
            dout_d[p*DATA_W +: DATA_W] = ent_d[p];
          end
          hit_d[p] = ent_v[p];
          rd_err   = 1'b1;
`endif
        end else if (ent_v[p]) begin
          dout_d[p*DATA_W +: DATA_W] = ent_d[p];
          hit_d[p]                   = 1'b1;
        end
      end
    end
    err_d = wr_oor || rd_err;
  end

  // Clear is applied before the same-cycle write; occupancy follows the new valid set
  always_comb begin
    valid_d = clr ? '0 : valid_q;
    valid_d = valid_d | wr_sel;
    cnt_d   = '0;
    for (int i = 0; i < DATA_N; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(valid_d[i]);
    end
  end

  // Data storage write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_N; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= din;
      end
    end
  end

  // Valid bits, read responses, error and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      dout_q       <= '0;
      rd_v_q       <= '0;
      hit_q        <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      dout_q       <= dout_d;
      rd_v_q       <= rd;
      hit_q        <= hit_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_q || err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign rd_v       = rd_v_q;
  assign rd_hit     = hit_q;
  assign error      = err_q;
  assign err_sticky = err_sticky_q;
  assign valid_cnt  = cnt_q;

endmodule

// File: tb/tb_flop_array_mp.sv
// tb/tb_flop_array_mp.sv - scoreboard testbench for flop_array_mp
module tb_flop_array_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [2:0]  waddr;
  logic [7:0]  din;
  logic        clr;
  logic [1:0]  rd;
  logic [5:0]  raddr;
  logic [15:0] dout,  dout6;
  logic [1:0]  rd_v,  rd_v6;
  logic [1:0]  rd_hit, rd_hit6;
  logic        error, error6;
  logic        err_sticky, err_sticky6;
  logic [3:0]  valid_cnt, valid_cnt6;

  int checks   = 0;
  int failures = 0;

`ifdef FFA_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int         dut;
    int         port;
    logic [7:0] data;
    logic       hit;
  } exp_t;

  exp_t sb[$];

  // reference model of the 8-entry instance
  logic [7:0] m_mem [8];
  logic [7:0] m_v;

  always #5 clk = ~clk;

  flop_array_mp #(.DATA_W(8), .ADDR_W(3), .DATA_N(8), .RD_PORTS(2)) u_dut (
    .clk(clk), .reset(reset), .wr(wr), .waddr(waddr), .din(din), .clr(clr),
    .rd(rd), .raddr(raddr), .dout(dout), .rd_v(rd_v), .rd_hit(rd_hit),
    .error(error), .err_sticky(err_sticky), .valid_cnt(valid_cnt)
  );

  flop_array_mp #(.DATA_W(8), .ADDR_W(3), .DATA_N(6), .RD_PORTS(2)) u_dut6 (
    .clk(clk), .reset(reset), .wr(wr), .waddr(waddr), .din(din), .clr(clr),
    .rd(rd), .raddr(raddr), .dout(dout6), .rd_v(rd_v6), .rd_hit(rd_hit6),
    .error(error6), .err_sticky(err_sticky6), .valid_cnt(valid_cnt6)
  );

  task automatic idle();
    wr = 1'b0; waddr = '0; din = '0; clr = 1'b0; rd = '0; raddr = '0;
  endtask

  // queue expected read response for port p of dut d from the model (dut 0)
  task automatic push_model(input int p, input int a);
    exp_t e;
    e.dut = 0; e.port = p;
    if (a < 8 && m_v[a]) begin e.data = m_mem[a]; e.hit = 1'b1; end
    else begin e.data = 8'h00; e.hit = 1'b0; end
    sb.push_back(e);
  endtask

  task automatic push_const(input int d, input int p, input logic [7:0] data, input logic hit);
    exp_t e;
    e.dut = d; e.port = p; e.data = data; e.hit = hit;
    sb.push_back(e);
  endtask

  task automatic model_write(input int a, input logic [7:0] v);
    if (a < 8) begin m_mem[a] = v; m_v[a] = 1'b1; end
  endtask

  // advance one clock, then drain the scoreboard against the responses
  task automatic step();
    exp_t e;
    logic [7:0] d;
    logic v, h;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        d = dout[e.port*8 +: 8]; v = rd_v[e.port]; h = rd_hit[e.port];
      end else begin
        d = dout6[e.port*8 +: 8]; v = rd_v6[e.port]; h = rd_hit6[e.port];
      end
      checks += 3;
      if (v !== 1'b1) begin
        failures++;
        $display("FAIL rd_v dut%0d p%0d got=%b exp=1", e.dut, e.port, v);
      end
      if (h !== e.hit) begin
        failures++;
        $display("FAIL rd_hit dut%0d p%0d got=%b exp=%b", e.dut, e.port, h, e.hit);
      end
      if (d !== e.data) begin
        failures++;
        $display("FAIL dout dut%0d p%0d got=%h exp=%h", e.dut, e.port, d, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    m_v = '0;
    #12;
    checks++;
    if ({dout, rd_v, rd_hit, error, err_sticky, valid_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got dout=%h rd_v=%b hit=%b err=%b sticky=%b cnt=%0d exp all zero",
               dout, rd_v, rd_hit, error, err_sticky, valid_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_empty_read();
    rd = 2'b01; raddr = {3'd0, 3'd3};
    push_model(0, 3);
    step();
    idle();
    checks++;
    if (valid_cnt !== 4'd0) begin
      failures++;
      $display("FAIL empty_cnt got=%0d exp=0", valid_cnt);
    end
  endtask

  task automatic test_write_read();
    wr = 1'b1; waddr = 3'd2; din = 8'hA5;
    step();
    model_write(2, 8'hA5);
    idle();
    rd = 2'b11; raddr = {3'd2, 3'd2};
    push_model(0, 2); push_model(1, 2);
    step();
    idle();
    checks++;
    if (valid_cnt !== 4'd1) begin
      failures++;
      $display("FAIL wr_cnt got=%0d exp=1", valid_cnt);
    end
    step();
    checks++;
    if (rd_v !== 2'b00 || dout !== 16'h0 || rd_hit !== 2'b00) begin
      failures++;
      $display("FAIL idle_resp got rd_v=%b dout=%h hit=%b exp 0", rd_v, dout, rd_hit);
    end
  endtask

  task automatic test_collision();
    wr = 1'b1; waddr = 3'd5; din = 8'h22;
    step();
    model_write(5, 8'h22);
    idle();
    wr = 1'b1; waddr = 3'd5; din = 8'h11;
    rd = 2'b10; raddr = {3'd5, 3'd0};
    push_const(0, 1, BYPASS ? 8'h11 : 8'h22, 1'b1);
    step();
    model_write(5, 8'h11);
    idle();
    checks += 3;
    if (error !== !BYPASS) begin
      failures++;
      $display("FAIL coll_error got=%b exp=%b", error, !BYPASS);
    end
    if (err_sticky !== !BYPASS) begin
      failures++;
      $display("FAIL coll_sticky got=%b exp=%b", err_sticky, !BYPASS);
    end
    if (valid_cnt !== 4'd2) begin
      failures++;
      $display("FAIL coll_cnt got=%0d exp=2", valid_cnt);
    end
    rd = 2'b01; raddr = {3'd0, 3'd5};
    push_model(0, 5);
    step();
    idle();
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL error_pulse_width got=%b exp=0", error);
    end
  endtask

  task automatic test_fill_clr();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; waddr = 3'(i); din = 8'h40 + 8'(i);
      step();
      model_write(i, 8'h40 + 8'(i));
    end
    idle();
    #1;
    checks++;
    if (valid_cnt !== 4'd8) begin
      failures++;
      $display("FAIL full_cnt got=%0d exp=8", valid_cnt);
    end
    wr = 1'b1; waddr = 3'd4; din = 8'h77;
    step();
    model_write(4, 8'h77);
    idle();
    checks++;
    if (valid_cnt !== 4'd8) begin
      failures++;
      $display("FAIL rewrite_cnt got=%0d exp=8", valid_cnt);
    end
    clr = 1'b1; wr = 1'b1; waddr = 3'd0; din = 8'h3C;
    rd = 2'b10; raddr = {3'd3, 3'd0};
    push_model(1, 3);
    step();
    m_v = '0;
    model_write(0, 8'h3C);
    idle();
    checks++;
    if (valid_cnt !== 4'd1) begin
      failures++;
      $display("FAIL clr_wr_cnt got=%0d exp=1", valid_cnt);
    end
    rd = 2'b11; raddr = {3'd1, 3'd0};
    push_const(0, 0, 8'h3C, 1'b1);
    push_const(0, 1, 8'h00, 1'b0);
    step();
    idle();
  endtask

  task automatic test_range();
    wr = 1'b1; waddr = 3'd7; din = 8'h99;
    step();
    model_write(7, 8'h99);
    idle();
    checks += 2;
    if (error6 !== 1'b1) begin
      failures++;
      $display("FAIL oor_wr_error got=%b exp=1", error6);
    end
    if (valid_cnt6 !== 4'd1) begin
      failures++;
      $display("FAIL oor_wr_cnt got=%0d exp=1", valid_cnt6);
    end
    rd = 2'b01; raddr = {3'd0, 3'd6};
    push_const(1, 0, 8'h00, 1'b0);
    push_model(0, 6);
    step();
    idle();
    checks += 2;
    if (error6 !== 1'b1) begin
      failures++;
      $display("FAIL oor_rd_error got=%b exp=1", error6);
    end
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL inrange_no_error got=%b exp=0", error);
    end
  endtask

  task automatic test_reset_mid();
    rd = 2'b01; raddr = {3'd0, 3'd7};
    push_const(1, 0, 8'h00, 1'b0);
    push_model(0, 7);
    step();
    idle();
    reset = 1'b1;
    #1;
    checks += 2;
    if ({rd_v, error, valid_cnt, err_sticky, dout} !== '0) begin
      failures++;
      $display("FAIL mid_reset got rd_v=%b err=%b cnt=%0d sticky=%b dout=%h exp 0",
               rd_v, error, valid_cnt, err_sticky, dout);
    end
    if ({rd_v6, error6, valid_cnt6, err_sticky6} !== '0) begin
      failures++;
      $display("FAIL mid_reset6 got rd_v=%b err=%b cnt=%0d sticky=%b exp 0",
               rd_v6, error6, valid_cnt6, err_sticky6);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_v = '0;
    rd = 2'b01; raddr = {3'd0, 3'd0};
    push_model(0, 0);
    step();
    idle();
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_write_read();
    test_collision();
    test_fill_clr();
    test_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
